// File: rtl/alu_defs.sv
// Shared definitions for the Kabeta iterative ALU.
//   alu_op_e : 4-bit operation codes. ADD..SRA keep the legacy ALU encoding;
//              MUL/DIV/MOD occupy previously unused values. 4'hE and 4'hF
//              remain undefined and produce Z=0 on the single-cycle path.
//   state_e  : handshake / multi-cycle sequencing states.
//   is_multi : true for operations that run on the iterative engine.
package alu_defs;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_CEQ = 4'd2,
      ALU_CLT = 4'd3,
      ALU_CLE = 4'd4,
      ALU_AND = 4'd5,
      ALU_ORR = 4'd6,
      ALU_XOR = 4'd7,
      ALU_SHL = 4'd8,
      ALU_SHR = 4'd9,
      ALU_SRA = 4'd10,
      ALU_MUL = 4'd11,
      ALU_DIV = 4'd12,
      ALU_MOD = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ITER = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   function automatic logic is_multi(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage

// File: rtl/iterative_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider.
//   Clock, Reset_n : clock, asynchronous active-low reset
//   load           : LOAD cycle; latch operands (magnitudes for DIV/MOD), signs
//   iter           : ITER cycle; produce one product or quotient bit
//   op             : operation code (MUL, DIV or MOD)
//   a, b           : captured operands X and Y
//   last           : counter has reached zero (final iteration this cycle)
//   result         : signed-corrected result, including the iteration in flight
//   div_zero       : divisor was zero for a DIV/MOD
module iterative_muldiv_core
   import alu_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             load,
   input  logic             iter,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   // acc : product accumulator (MUL) or partial remainder (DIV/MOD)
   // sh  : multiplier shifted out MSB-first, or dividend shifted out while
   //       quotient bits shift in
   logic [WIDTH-1:0] acc, sh, mcand;
   logic [WIDTH-1:0] acc_n, sh_n;
   logic [SHW-1:0]   cnt;
   logic             is_mul, is_div, neg_q, neg_r, dz;
   logic [WIDTH:0]   trial;
   logic             ge;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      trial = {acc, sh[WIDTH-1]};
      ge    = trial >= {1'b0, mcand};
      acc_n = acc;
      sh_n  = sh;
      if (is_mul) begin
         acc_n = (acc << 1) + (sh[WIDTH-1] ? mcand : '0);
         sh_n  = sh << 1;
      end else begin
         acc_n = ge ? WIDTH'(trial - {1'b0, mcand}) : trial[WIDTH-1:0];
         sh_n  = {sh[WIDTH-2:0], ge};
      end
   end

   // The result is taken from the next-state values so the final iteration
   // and the sign fix-up land in Z on the same edge.
   // With a zero divisor the remainder path ends holding |X|, so MOD
   // naturally returns X after the sign fix; only DIV needs an override.
   always_comb begin
      result = '0;
      if (is_mul)
         result = acc_n;
      else if (is_div)
         result = dz ? '1 : (neg_q ? -sh_n : sh_n);
      else
         result = neg_r ? -acc_n : acc_n;
   end

   assign last     = (cnt == '0);
   assign div_zero = dz;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt    <= '0;
         is_mul <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
      end else if (load) begin
         cnt    <= SHW'(WIDTH - 1);
         is_mul <= (op == ALU_MUL);
         is_div <= (op == ALU_DIV);
         neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r  <= a[WIDTH-1];
         dz     <= (b == '0) && (op != ALU_MUL);
      end else if (iter) begin
         cnt    <= cnt - 1'b1;
      end
   end

   // NOTE: the datapath registers are always loaded before use, so they carry no reset.
   always_ff @(posedge Clock) begin
      if (load) begin
         acc <= '0;
         if (op == ALU_MUL) begin
            sh    <= b;
            mcand <= a;
         end else begin
            sh    <= a[WIDTH-1] ? -a : a;
            mcand <= b[WIDTH-1] ? -b : b;
         end
      end else if (iter) begin
         acc <= acc_n;
         sh  <= sh_n;
      end
   end

endmodule

// File: rtl/iterative_alu.sv
// Kabeta iterative ALU: single-cycle ops plus multi-cycle MUL/DIV/MOD.
//   Clock, Reset_n : clock, asynchronous active-low reset
//   Start          : request an operation; accepted only when not Busy
//   OpCode         : operation select (alu_defs::alu_op_e)
//   X, Y           : operands, sampled on the accepting edge
//   Z              : result, held until the next Done
//   Busy           : multi-cycle operation in progress
//   Done           : one-cycle pulse; Z and DivZero valid
//   DivZero        : DIV/MOD with Y=0, held with Z
// The FIX state is the Done cycle of a multi-cycle op; it accepts Start
// exactly like IDLE so the execute stage can issue without a bubble.
module iterative_alu
   import alu_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [3:0]       OpCode,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Z,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   state_e           state, state_d;
   logic [WIDTH-1:0] z_d, alu_single, x_q, y_q, core_result;
   logic [3:0]       op_q;
   logic             done_d, dz_d, capture, core_last, core_dz;
   logic [SHW-1:0]   shamt;

   assign shamt = Y[SHW-1:0];

   always_comb begin
      alu_single = '0;
      case (OpCode)
         ALU_ADD: alu_single = X + Y;
         ALU_SUB: alu_single = X - Y;
         ALU_CEQ: alu_single = {{(WIDTH-1){1'b0}}, (X == Y)};
         ALU_CLT: alu_single = {{(WIDTH-1){1'b0}}, ($signed(X) <  $signed(Y))};
         ALU_CLE: alu_single = {{(WIDTH-1){1'b0}}, ($signed(X) <= $signed(Y))};
         ALU_AND: alu_single = X & Y;
         ALU_ORR: alu_single = X | Y;
         ALU_XOR: alu_single = X ^ Y;
         ALU_SHL: alu_single = X << shamt;
         ALU_SHR: alu_single = X >> shamt;
         ALU_SRA: alu_single = $signed(X) >>> shamt;
         default: alu_single = '0;
      endcase
   end

   always_comb begin
      state_d = state;
      z_d     = Z;
      done_d  = 1'b0;
      dz_d    = DivZero;
      capture = 1'b0;
      case (state)
         ST_IDLE, ST_FIX: begin
            state_d = ST_IDLE;
            if (Start) begin
               if (is_multi(OpCode)) begin
                  state_d = ST_LOAD;
                  capture = 1'b1;
               end else begin
                  z_d    = alu_single;
                  done_d = 1'b1;
                  dz_d   = 1'b0;
               end
            end
         end
         ST_LOAD: state_d = ST_ITER;
         ST_ITER: begin
            if (core_last) begin
               state_d = ST_FIX;
               z_d     = core_result;
               dz_d    = core_dz;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_IDLE;
         Z       <= '0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         state   <= state_d;
         Z       <= z_d;
         Done    <= done_d;
         DivZero <= dz_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (capture) begin
         x_q  <= X;
         y_q  <= Y;
         op_q <= OpCode;
      end
   end

   assign Busy = (state == ST_LOAD) || (state == ST_ITER);

   iterative_muldiv_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .load     (state == ST_LOAD),
      .iter     (state == ST_ITER),
      .op       (op_q),
      .a        (x_q),
      .b        (y_q),
      .last     (core_last),
      .result   (core_result),
      .div_zero (core_dz)
   );

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu (WIDTH=32 main instance, WIDTH=16 latency instance).
module tb_iterative_alu;
   import alu_defs::*;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic [3:0]  OpCode;
   logic [31:0] X, Y, Z;
   logic        Busy, Done, DivZero;

   logic        b_start;
   logic [3:0]  b_op;
   logic [15:0] b_x, b_y, b_z;
   logic        b_busy, b_done, b_dz;

   int checks   = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   iterative_alu #(.WIDTH(32)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Start   (Start),
      .OpCode  (OpCode),
      .X       (X),
      .Y       (Y),
      .Z       (Z),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero)
   );

   iterative_alu #(.WIDTH(16)) dut16 (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Start   (b_start),
      .OpCode  (b_op),
      .X       (b_x),
      .Y       (b_y),
      .Z       (b_z),
      .Busy    (b_busy),
      .Done    (b_done),
      .DivZero (b_dz)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Issue one op in the current cycle (cycle 0) and wait for Done.
   // lat = cycle of Done; busy_cnt = cycles with Busy=1 before Done.
   // At cycle inject_at (if > 0) an ADD 1+1 is presented, which must be ignored.
   task automatic op_check(input string tag, input logic [3:0] op,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_z, input logic exp_dz,
                           input int exp_lat, input int inject_at);
      int lat;
      int busy_cnt;
      OpCode = op; X = x; Y = y; Start = 1'b1;
      step();
      Start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!Done && lat < 100) begin
         busy_cnt += int'(Busy);
         if (lat == inject_at) begin
            Start = 1'b1; OpCode = ALU_ADD; X = 32'd1; Y = 32'd1;
         end
         step();
         Start = 1'b0;
         lat++;
      end
      check({tag, "_lat"},  lat, exp_lat);
      check({tag, "_busy"}, busy_cnt, exp_lat - 1);
      check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
      check({tag, "_z"},    Z, exp_z);
      check({tag, "_dz"},   {31'd0, DivZero}, {31'd0, exp_dz});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_seen;
      int lat;

      Reset_n = 1'b0; Start = 1'b0; OpCode = ALU_ADD; X = '0; Y = '0;
      b_start = 1'b0; b_op = ALU_ADD; b_x = '0; b_y = '0;
      step();
      step();
      check("rst_z",    Z, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_dz",   {31'd0, DivZero}, 32'd0);
      Reset_n = 1'b1;
      step();

      // Back-to-back ADDs, one per cycle with no bubbles.
      OpCode = ALU_ADD; X = 32'h7FFF_FFFF; Y = 32'd1; Start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("b2b_done", {31'd0, Done}, 32'd1);
         check("b2b_busy", {31'd0, Busy}, 32'd0);
         check("b2b_z",    Z, 32'h7FFF_FFFF + 32'(i + 1));
         Y = 32'(i + 2);
         if (i == 7) Start = 1'b0;
      end
      step();
      check("b2b_idle_done", {31'd0, Done}, 32'd0);

      // MUL with an ignored Start during Busy.
      op_check("mul_neg", ALU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 34, 5);
      step();
      check("mul_no_extra_done", {31'd0, Done}, 32'd0);

      // Chained ops: each Start is issued in the previous Done cycle.
      op_check("mul_wrap", ALU_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 34, 0);
      op_check("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, 0);
      op_check("mod_m7_2", ALU_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, 0);
      op_check("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, 0);
      op_check("mod_7_m2", ALU_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 34, 0);
      op_check("div_ovf",  ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34, 0);
      op_check("div_zero", ALU_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 34, 0);
      op_check("add_clr",  ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
      op_check("mod_zero", ALU_MOD, 32'd100, 32'd0, 32'd100, 1'b1, 34, 0);
      op_check("clt_m1_0", ALU_CLT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1, 0);
      op_check("clt_0_m1", ALU_CLT, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
      op_check("cle_eq",   ALU_CLE, 32'd5, 32'd5, 32'd1, 1'b0, 1, 0);
      op_check("ceq",      ALU_CEQ, 32'd9, 32'd9, 32'd1, 1'b0, 1, 0);
      op_check("sub",      ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, 0);
      op_check("sra",      ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1, 0);
      op_check("shr",      ALU_SHR, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 0);
      op_check("shl_wrap", ALU_SHL, 32'd5, 32'h21, 32'd10, 1'b0, 1, 0);
      op_check("and",      ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1, 0);
      op_check("orr",      ALU_ORR, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1, 0);
      op_check("xor",      ALU_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1, 0);
      op_check("undef",    4'hF,    32'd3, 32'd4, 32'd0, 1'b0, 1, 0);

      // Reset in cycle 10 of a MUL, with Z and DivZero non-zero beforehand.
      op_check("pre_rst",  ALU_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 34, 0);
      OpCode = ALU_MUL; X = 32'hFFFF_FFFD; Y = 32'd7; Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (9) step();
      check("rst_mid_busy_before", {31'd0, Busy}, 32'd1);
      Reset_n = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, Busy}, 32'd0);
      check("rst_mid_done", {31'd0, Done}, 32'd0);
      check("rst_mid_z",    Z, 32'd0);
      check("rst_mid_dz",   {31'd0, DivZero}, 32'd0);
      step();
      Reset_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         step();
         done_seen += int'(Done) + int'(Busy);
      end
      check("rst_no_done", done_seen, 0);
      op_check("post_rst_add", ALU_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1, 0);

      // WIDTH=16 instance: MUL latency WIDTH+2 = 18.
      b_op = ALU_MUL; b_x = 16'hFFFD; b_y = 16'd7; b_start = 1'b1;
      step();
      b_start = 1'b0;
      lat = 1;
      while (!b_done && lat < 100) begin
         step();
         lat++;
      end
      check("w16_mul_lat", lat, 18);
      check("w16_mul_z",   {16'd0, b_z}, 32'h0000_FFEB);
      check("w16_mul_busy", {31'd0, b_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
